br_resolve_stage: RTL and testbench
===================================

Name: br_resolve_stage

Overview:
- Branch-resolution stage in EX. It sits directly downstream of the operand-select logic and wraps the signed/unsigned less-than compare.
- Evaluates RV32I conditional branches on rs1/rs2 and registers the result. Produces taken, redirect PC and mispredict for the fetch/flush logic.
- One registered output slot with a valid/ready handshake. Saturating statistics counters for branches and mispredicts.

Parameters:
- XLEN, 32, operand/PC width.
- CNT_W, 16, width of each statistics counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous kill of the held result and the incoming transfer.
- i_valid  in  1  upstream presents a branch.
- o_ready  out  1  stage can accept this cycle.
- i_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- i_rs1  in  XLEN  operand 1.
- i_rs2  in  XLEN  operand 2.
- i_pc  in  XLEN  branch PC.
- i_imm  in  XLEN  sign-extended B-immediate.
- i_pred_taken  in  1  fetch prediction.
- o_valid  out  1  result held.
- i_ready  in  1  downstream accepts.
- o_taken  out  1  branch condition true.
- o_mispredict  out  1  o_taken != prediction, or illegal funct3.
- o_redirect_pc  out  XLEN  correct next PC.
- o_illegal  out  1  funct3 was 010 or 011.
- o_cnt_branch  out  CNT_W  accepted branches.
- o_cnt_mispredict  out  CNT_W  accepted mispredicts.

Behaviour:
- Reset (asynchronous, i_rst_n=0) clears every output register to 0: o_valid, o_taken, o_mispredict, o_redirect_pc, o_illegal, o_cnt_branch, o_cnt_mispredict. Reset mid-transfer drops the held result with no partial count.
- o_ready = !o_valid | i_ready (combinational). Accept = i_valid & o_ready & !i_flush.
- Latency: one cycle. Accepted inputs appear on the outputs at the next edge with o_valid=1.
- Output slot states:
  - EMPTY, o_valid=0:
    - accept -> FULL.
  - FULL, o_valid=1:
    - i_ready & accept -> FULL with new data (back-to-back, no bubble).
    - i_ready & !accept -> EMPTY.
    - !i_ready -> hold; all outputs stable, no input accepted.
- Flush: i_flush=1 forces o_valid=0 at the next edge, regardless of i_ready and i_valid. Counters are not updated for that cycle's input. Flush has priority over accept.
- Compare, combinational on the inputs and registered at accept:
  - eq = (rs1 == rs2).
  - lt_s = signed rs1 < rs2. When the signs differ, the result is rs1[XLEN-1]. Otherwise it is the MSB of rs1 + ~rs2 + 1.
  - lt_u = unsigned rs1 < rs2, i.e. the borrow of the same subtraction.
  - Taken per funct3:
    - BEQ = eq.
    - BNE = !eq.
    - BLT = lt_s.
    - BGE = !lt_s.
    - BLTU = lt_u.
    - BGEU = !lt_u.
- Illegal funct3 (010, 011): o_illegal=1, o_taken=0, o_mispredict=1, o_redirect_pc = pc+4.
- o_redirect_pc = taken ? pc+imm : pc+4. Arithmetic is modulo 2^XLEN and wraps silently.
- o_mispredict = (taken != i_pred_taken) | illegal.
- Counters, updated at accept only:
  - o_cnt_branch increments by 1 per accept.
  - o_cnt_mispredict increments when that accept mispredicts.
  - Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- BLT signed: rs1=0xFFFFFFFF (-1), rs2=0x00000001, pc=0x100, imm=0x20, pred=0 -> next cycle o_valid=1, o_taken=1, o_redirect_pc=0x120, o_mispredict=1, cnt_branch=1, cnt_mispredict=1.
- BLTU on the same operands, pred=0 -> o_taken=0, o_redirect_pc=0x104, o_mispredict=0. BGE with rs1=0x80000000, rs2=0x7FFFFFFF -> o_taken=0.
- Backpressure: issue a result, hold i_ready=0 for 3 cycles while i_valid=1 with new data -> o_ready=0, outputs stable, counters unchanged. Release i_ready -> the second branch is accepted, with no bubble between the two results.
- Flush: o_valid=1 and i_valid=1 in the same cycle as i_flush=1 -> o_valid=0 next cycle, counters unchanged.
- Illegal funct3=010, pc=0xFFFFFFFC -> o_illegal=1, o_taken=0, o_mispredict=1, o_redirect_pc=0x00000000 (wrap).
- Saturation with CNT_W=4: 17 accepted mispredicting branches -> both counters = 15. Assert i_rst_n low while o_valid=1 -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/br_resolve_stage_if.sv
// Branch-resolution stage bus: upstream branch request, flush, downstream
// handshake, resolved result and statistics counters.
interface br_resolve_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_rs1;
  logic [XLEN-1:0]  i_rs2;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_imm;
  logic             i_pred_taken;
  logic             o_valid;
  logic             i_ready;
  logic             o_taken;
  logic             o_mispredict;
  logic [XLEN-1:0]  o_redirect_pc;
  logic             o_illegal;
  logic [CNT_W-1:0] o_cnt_branch;
  logic [CNT_W-1:0] o_cnt_mispredict;

  // Stage side: consumes the branch request, produces the result.
  modport slave (
    input  i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_pc, i_imm,
           i_pred_taken, i_ready,
    output o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
           o_illegal, o_cnt_branch, o_cnt_mispredict
  );

  // Environment side: drives requests and downstream ready.
  modport master (
    output i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_pc, i_imm,
           i_pred_taken, i_ready,
    input  o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
           o_illegal, o_cnt_branch, o_cnt_mispredict
  );
endinterface

// File: rtl/br_resolve_stage.sv
// EX-stage branch resolution: evaluates RV32I conditional branches, computes
// the correct next PC and mispredict flag, and holds the result in a single
// valid/ready output slot alongside saturating branch/mispredict counters.
module br_resolve_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  br_resolve_stage_if.slave bus
);

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    if (en && (cnt != {CNT_W{1'b1}}))
      return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic              accept_p0;
  logic              vld_p0;
  logic [XLEN:0]     diff_p0;
  logic              eq_p0;
  logic              lt_s_p0;
  logic              lt_u_p0;
  logic              taken_p0;
  logic              illegal_p0;
  logic              mispredict_p0;
  logic [XLEN-1:0]   target_p0;
  logic [XLEN-1:0]   fallthru_p0;
  logic [XLEN-1:0]   redirect_p0;
  logic signed [XLEN-1:0] rs1_s_p0;

  // ---- stage p0: handshake and combinational compare on the inputs ----
  assign bus.o_ready = !bus.o_valid || bus.i_ready;
  assign vld_p0      = bus.i_valid;
  assign accept_p0   = vld_p0 && bus.o_ready && !bus.i_flush;

  // rs1 + ~rs2 + 1 with a carry bit: carry-out set means rs1 >= rs2 unsigned.
  assign diff_p0  = {1'b0, bus.i_rs1} + {1'b0, ~bus.i_rs2} + {{XLEN{1'b0}}, 1'b1};
  assign rs1_s_p0 = $signed(bus.i_rs1);
  assign eq_p0    = (bus.i_rs1 == bus.i_rs2);
  assign lt_u_p0  = !diff_p0[XLEN];
  // With differing signs the negative operand is the smaller one; otherwise
  // the subtraction cannot overflow and its sign bit is the answer.
  assign lt_s_p0  = (bus.i_rs1[XLEN-1] != bus.i_rs2[XLEN-1]) ? rs1_s_p0[XLEN-1]
                                                             : diff_p0[XLEN-1];

  // Select the branch condition; 010/011 are not branches and never taken.
  always_comb begin
    taken_p0   = 1'b0;
    illegal_p0 = 1'b0;
    case (bus.i_funct3)
      F_BEQ:   taken_p0 = eq_p0;
      F_BNE:   taken_p0 = !eq_p0;
      F_BLT:   taken_p0 = lt_s_p0;
      F_BGE:   taken_p0 = !lt_s_p0;
      F_BLTU:  taken_p0 = lt_u_p0;
      F_BGEU:  taken_p0 = !lt_u_p0;
      default: illegal_p0 = 1'b1;
    endcase
  end

  // PC arithmetic wraps modulo 2^XLEN.
  assign target_p0     = bus.i_pc + bus.i_imm;
  assign fallthru_p0   = bus.i_pc + XLEN'(4);
  assign redirect_p0   = taken_p0 ? target_p0 : fallthru_p0;
  assign mispredict_p0 = (taken_p0 != bus.i_pred_taken) || illegal_p0;

  // ---- stage p1: output slot register and statistics counters ----
  // Flush beats accept; a drained slot with no new accept goes empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid          <= 1'b0;
      bus.o_taken          <= 1'b0;
      bus.o_mispredict     <= 1'b0;
      bus.o_redirect_pc    <= '0;
      bus.o_illegal        <= 1'b0;
      bus.o_cnt_branch     <= '0;
      bus.o_cnt_mispredict <= '0;
    end else if (bus.i_flush) begin
      bus.o_valid <= 1'b0;
    end else if (accept_p0) begin
      bus.o_valid          <= 1'b1;
      bus.o_taken          <= taken_p0;
      bus.o_mispredict     <= mispredict_p0;
      bus.o_redirect_pc    <= redirect_p0;
      bus.o_illegal        <= illegal_p0;
      bus.o_cnt_branch     <= sat_inc(bus.o_cnt_branch, 1'b1);
      bus.o_cnt_mispredict <= sat_inc(bus.o_cnt_mispredict, mispredict_p0);
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_br_resolve_stage.sv
// Bench for br_resolve_stage: directed branch cases, backpressure, flush,
// illegal funct3, randomized traffic and counter saturation, all checked
// against a behavioural model of the output slot.
module tb_br_resolve_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  br_resolve_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  br_resolve_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic        mv;
  logic        mt, mm, mi;
  logic [31:0] mpc;
  int          mcb, mcm;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch semantics from the ISA definition using native comparisons.
  function automatic void ref_eval(input logic [2:0] f, input logic [31:0] a, b, pc, imm,
                                   input logic pred, output logic t, m, il,
                                   output logic [31:0] rpc);
    int signed sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    il = 1'b0;
    t  = 1'b0;
    case (f)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (sa < sb);
      3'd5: t = (sa >= sb);
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: il = 1'b1;
    endcase
    rpc = t ? (pc + imm) : (pc + 32'd4);
    m   = (t != pred) || il;
  endfunction

  task automatic check_outputs(input string tag);
    check($sformatf("%s.valid", tag), 64'(bus.o_valid), 64'(mv));
    if (mv) begin
      check($sformatf("%s.taken", tag), 64'(bus.o_taken), 64'(mt));
      check($sformatf("%s.mispredict", tag), 64'(bus.o_mispredict), 64'(mm));
      check($sformatf("%s.illegal", tag), 64'(bus.o_illegal), 64'(mi));
      check($sformatf("%s.redirect", tag), 64'(bus.o_redirect_pc), 64'(mpc));
    end
    check($sformatf("%s.cnt_branch", tag), 64'(bus.o_cnt_branch), 64'(mcb));
    check($sformatf("%s.cnt_mispredict", tag), 64'(bus.o_cnt_mispredict), 64'(mcm));
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s.valid", tag), 64'(bus.o_valid), 64'd0);
    check($sformatf("%s.taken", tag), 64'(bus.o_taken), 64'd0);
    check($sformatf("%s.mispredict", tag), 64'(bus.o_mispredict), 64'd0);
    check($sformatf("%s.illegal", tag), 64'(bus.o_illegal), 64'd0);
    check($sformatf("%s.redirect", tag), 64'(bus.o_redirect_pc), 64'd0);
    check($sformatf("%s.cnt_branch", tag), 64'(bus.o_cnt_branch), 64'd0);
    check($sformatf("%s.cnt_mispredict", tag), 64'(bus.o_cnt_mispredict), 64'd0);
  endtask

  task automatic model_reset();
    mv = 0; mt = 0; mm = 0; mi = 0; mpc = '0; mcb = 0; mcm = 0;
  endtask

  // One clock with the currently driven inputs; model follows the slot rules.
  task automatic step(input string tag);
    logic acc, t, m, il;
    logic [31:0] r;
    #1;
    check($sformatf("%s.ready", tag), 64'(bus.o_ready), 64'(!mv || bus.i_ready));
    acc = bus.i_valid && (!mv || bus.i_ready) && !bus.i_flush;
    ref_eval(bus.i_funct3, bus.i_rs1, bus.i_rs2, bus.i_pc, bus.i_imm, bus.i_pred_taken,
             t, m, il, r);
    @(posedge clk);
    if (bus.i_flush) mv = 0;
    else if (acc) begin
      mv = 1; mt = t; mm = m; mi = il; mpc = r;
      if (mcb < CMAX) mcb++;
      if (m && mcm < CMAX) mcm++;
    end else if (bus.i_ready) mv = 0;
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, b, pc, imm,
                       input logic pred, input logic rdy, input logic fl);
    bus.i_valid = v; bus.i_funct3 = f; bus.i_rs1 = a; bus.i_rs2 = b;
    bus.i_pc = pc; bus.i_imm = imm; bus.i_pred_taken = pred;
    bus.i_ready = rdy; bus.i_flush = fl;
  endtask

  initial begin
    logic [31:0] ra, rb, snap_pc;
    int snap_cb, snap_cm;
    rst_n = 1'b0;
    drive(0, 3'd0, '0, '0, '0, '0, 0, 1, 0);
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BLT signed: -1 < 1
    drive(1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0, 1, 0);
    step("blt");
    check("blt.taken_c", 64'(bus.o_taken), 64'd1);
    check("blt.redirect_c", 64'(bus.o_redirect_pc), 64'h120);
    check("blt.cnt_c", 64'({bus.o_cnt_branch, bus.o_cnt_mispredict}), 64'h11);

    // BLTU on the same operands: 0xFFFFFFFF is not below 1
    drive(1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0, 1, 0);
    step("bltu");
    check("bltu.redirect_c", 64'(bus.o_redirect_pc), 64'h104);
    check("bltu.mispredict_c", 64'(bus.o_mispredict), 64'd0);

    // BGE: most negative vs most positive
    drive(1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'h40, 1, 1, 0);
    step("bge");
    check("bge.taken_c", 64'(bus.o_taken), 64'd0);

    // Backpressure: hold three cycles with a new branch waiting
    snap_pc = mpc; snap_cb = mcb; snap_cm = mcm;
    drive(1, 3'b000, 32'h55, 32'h55, 32'h300, 32'hFFFF_FFF0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold.ready_c", 64'(bus.o_ready), 64'd0);
      check("bp_hold.pc_stable", 64'(bus.o_redirect_pc), 64'(snap_pc));
      check("bp_hold.cnt_stable", 64'(bus.o_cnt_branch), 64'(snap_cb));
    end
    bus.i_ready = 1;
    step("bp_release");
    check("bp_release.valid_c", 64'(bus.o_valid), 64'd1);
    check("bp_release.redirect_c", 64'(bus.o_redirect_pc), 64'h2F0);

    // Flush with a held result and a new request in the same cycle
    snap_cb = mcb; snap_cm = mcm;
    drive(1, 3'b001, 32'h1, 32'h2, 32'h400, 32'h8, 0, 0, 1);
    step("flush");
    check("flush.valid_c", 64'(bus.o_valid), 64'd0);
    check("flush.cnt_c", 64'(bus.o_cnt_mispredict), 64'(snap_cm));

    // Illegal funct3 with fall-through wrapping past zero
    drive(1, 3'b010, 32'h3, 32'h3, 32'hFFFF_FFFC, 32'h10, 0, 1, 0);
    step("illegal");
    check("illegal.redirect_c", 64'(bus.o_redirect_pc), 64'h0);
    check("illegal.flag_c", 64'(bus.o_illegal), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 32'h8000_0000;
        default: rb = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb, $urandom, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      step("rand");
    end

    // Saturation from a clean reset: 17 mispredicting accepts
    drive(0, 3'd0, '0, '0, '0, '0, 0, 1, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all_zero("reset2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 3'b000, 32'(i), 32'(i), 32'(i * 4), 32'h10, 0, 1, 0);
      step("sat");
    end
    check("sat.cnt_branch_c", 64'(bus.o_cnt_branch), 64'(CMAX));
    check("sat.cnt_mispredict_c", 64'(bus.o_cnt_mispredict), 64'(CMAX));

    // Asynchronous reset while a result is held
    check("async.pre_valid", 64'(bus.o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    #3;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
